mem_port_arbiter: RTL and testbench

- Shares the single processor memory port (cs, read_req, write_req, addrout, datatomem, datafrommem, mem_resp) between NUM_REQ requesters, e.g. instruction fetch and data load/store.
- Round-robin arbitration, one outstanding transaction at a time, per-requester response return, and a timeout watchdog on mem_resp.
- Sits between the processor core's fetch/LSU units and the memory model/controller.

---
 rtl/tinyalu_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types and widths for the processor memory-port logic.
//   MEM_ADDR_W / MEM_DATA_W : memory address and data widths
//   arb_state_t             : arbiter FSM state encoding
//   idx_width()             : index width for a requester count (minimum 1 bit)
package tinyalu_pkg;

  localparam int unsigned MEM_ADDR_W = 14;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic [0:0] {
    ARB_IDLE      = 1'b0,
    ARB_WAIT_RESP = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req_i        : request vector, one bit per requester
//   last_grant_i : index of the most recently served requester
//   winner_c     : first requester with req set, searching from last_grant_i+1 with wrap
//   any_valid_c  : at least one request bit is set
module rr_pick
  import tinyalu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   winner_c,
  output logic               any_valid_c
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    winner_c    = '0;
    any_valid_c = 1'b0;
    cand        = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant_i) + i) % int'(NUM_REQ));
      if (req_i[cand]) begin
        winner_c    = cand;
        any_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one processor memory port between NUM_REQ requesters.
// Round-robin grant, a single outstanding transaction, per-requester response
// pulse, and a watchdog that completes a transaction with an error when
// mem_resp does not arrive within TIMEOUT_CYCLES (0 disables the watchdog).
//   clk, reset                       : clock, synchronous active-high reset
//   req_valid/write/addr/wdata       : per-requester request (packed vectors)
//   req_ack                          : one-cycle accept pulse per requester
//   rsp_valid, rsp_rdata, rsp_err    : completion pulse, read data, timeout flag
//   cs, read_req, write_req          : memory strobes, held for the transaction
//   addrout, datatomem, datafrommem  : memory address / write data / read data
//   mem_resp                         : memory completion pulse
//   busy                             : arbiter not idle
module mem_port_arbiter
  import tinyalu_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*MEM_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*MEM_DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [MEM_DATA_W-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          cs,
  output logic                          read_req,
  output logic                          write_req,
  output logic [MEM_ADDR_W-1:0]         addrout,
  output logic [MEM_DATA_W-1:0]         datatomem,
  input  logic [MEM_DATA_W-1:0]         datafrommem,
  input  logic                          mem_resp,
  output logic                          busy
);

  localparam int unsigned IDX_W   = idx_width(NUM_REQ);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic                  write_q, write_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic                  cs_q, cs_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [MEM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  logic [IDX_W-1:0]      winner_c;
  logic                  any_valid_c;
  logic                  timeout_hit_c;

  logic [MEM_ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [MEM_DATA_W-1:0] wdata_arr[NUM_REQ];

  // Unpack the flat request buses into per-requester lanes.
  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*MEM_ADDR_W +: MEM_ADDR_W];
    assign wdata_arr[g] = req_wdata[g*MEM_DATA_W +: MEM_DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .winner_c     (winner_c),
    .any_valid_c  (any_valid_c)
  );

  assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cs_d         = cs_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    ack_d        = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        // A stray mem_resp here is deliberately ignored.
        if (any_valid_c) begin
          ack_d[winner_c] = 1'b1;
          owner_d         = winner_c;
          write_d         = req_write[winner_c];
          addr_d          = addr_arr[winner_c];
          wdata_d         = wdata_arr[winner_c];
          cs_d            = 1'b1;
          rd_d            = ~req_write[winner_c];
          wr_d            = req_write[winner_c];
          cnt_d           = '0;
          state_d         = ARB_WAIT_RESP;
        end
      end
      ARB_WAIT_RESP: begin
        // mem_resp takes precedence over a timeout in the same cycle.
        if (mem_resp || timeout_hit_c) begin
          cs_d                 = 1'b0;
          rd_d                 = 1'b0;
          wr_d                 = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = ~mem_resp;
          rsp_rdata_d          = (mem_resp && !write_q) ? datafrommem : '0;
          last_grant_d         = owner_q;
          cnt_d                = '0;
          state_d              = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cs_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cs_q         <= cs_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ack_q        <= ack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ack   = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cs        = cs_q;
  assign read_req  = rd_q;
  assign write_req = wr_q;
  assign addrout   = addr_q;
  assign datatomem = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Acks and responses are checked against expectation queues filled as
// requests are driven; the bench also plays the memory.
module tb_mem_port_arbiter;

  localparam int unsigned NR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid, req_write;
  logic [NR*14-1:0] req_addr;
  logic [NR*16-1:0] req_wdata;
  logic [NR-1:0] req_ack, rsp_valid;
  logic [15:0]   rsp_rdata, datatomem, datafrommem;
  logic          rsp_err, cs, read_req, write_req, mem_resp, busy;
  logic [13:0]   addrout;

  mem_port_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cs(cs), .read_req(read_req), .write_req(write_req), .addrout(addrout),
    .datatomem(datatomem), .datafrommem(datafrommem), .mem_resp(mem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [15:0] d;
    logic        e;
  } rsp_t;

  rsp_t rsp_q[$];
  int   ack_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [13:0] exp_addr;
  logic [15:0] exp_wd;
  logic        exp_wr;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every ack/response pulse must match the head of its queue.
  always @(negedge clk) begin
    rsp_t e;
    int   r;
    if (req_ack != '0) begin
      if (ack_q.size() == 0) chk_eq("ack_unexpected", 32'(req_ack), 32'd0);
      else begin
        r = ack_q.pop_front();
        chk_eq("ack_vec", 32'(req_ack), 32'(1) << r);
      end
    end
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) chk_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        e = rsp_q.pop_front();
        chk_eq("rsp_vec", 32'(rsp_valid), 32'(1) << e.r);
        chk_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
        chk_eq("rsp_err", 32'(rsp_err), 32'(e.e));
      end
    end
  end

  task automatic push_rsp(input int r, input logic [15:0] d, input logic e);
    rsp_t x;
    x.r = r; x.d = d; x.e = e;
    rsp_q.push_back(x);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ack == '0 && n < 16);
  endtask

  task automatic check_port_held(input string tag);
    chk_eq({tag, "_cs"}, 32'(cs), 32'd1);
    chk_eq({tag, "_rd"}, 32'(read_req), 32'(!exp_wr));
    chk_eq({tag, "_wr"}, 32'(write_req), 32'(exp_wr));
    chk_eq({tag, "_addr"}, 32'(addrout), 32'(exp_addr));
    if (exp_wr) chk_eq({tag, "_wdata"}, 32'(datatomem), 32'(exp_wd));
  endtask

  task automatic issue(input int r, input logic wr, input logic [13:0] a, input logic [15:0] wd);
    int n;
    req_write[r]          = wr;
    req_addr[r*14 +: 14]  = a;
    req_wdata[r*16 +: 16] = wd;
    req_valid[r]          = 1'b1;
    ack_q.push_back(r);
    exp_addr = a; exp_wd = wd; exp_wr = wr;
    wait_ack(n);
    req_valid[r] = 1'b0;
    chk_eq("ack_lat", 32'(n), 32'd1);
    check_port_held("grant");
    chk_eq("grant_busy", 32'(busy), 32'd1);
  endtask

  // Memory side: respond lat cycles after cs was first seen.
  task automatic mem_reply(input int lat, input logic [15:0] data);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check_port_held("hold");
    end
    mem_resp = 1'b1; datafrommem = data;
    @(negedge clk);
    mem_resp = 1'b0; datafrommem = '0;
    chk_eq("done_cs", 32'(cs), 32'd0);
    chk_eq("done_rd", 32'(read_req), 32'd0);
    chk_eq("done_wr", 32'(write_req), 32'd0);
    chk_eq("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_resp = 1'b0; datafrommem = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_outs", {req_ack, rsp_valid, rsp_err, cs, read_req, write_req, busy}, 32'd0);
    chk_eq("rst_data", {addrout, datatomem}, 32'd0);
    chk_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single read from requester 0.
    push_rsp(0, 16'hBEEF, 1'b0);
    issue(0, 1'b0, 14'h0123, 16'h0);
    mem_reply(3, 16'hBEEF);
    @(negedge clk);
    chk_eq("read_busy_after", 32'(busy), 32'd0);

    // Single write from requester 1; memory drives junk read data that must not leak.
    push_rsp(1, 16'h0000, 1'b0);
    issue(1, 1'b1, 14'h3FFF, 16'h55AA);
    mem_reply(3, 16'hDEAD);
    @(negedge clk);

    // Contention: both requesters continuously pending.
    req_write = '0;
    req_addr  = {14'h0101, 14'h0100};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ack_q.push_back(k % 2);
      push_rsp(k % 2, 16'h1000 + 16'(k), 1'b0);
      exp_addr = 14'h0100 + 14'(k % 2); exp_wr = 1'b0;
      wait_ack(n);
      if (k == 3) req_valid = '0;
      chk_eq("cont_ack_lat", 32'(n), 32'd1);
      check_port_held("cont");
      mem_reply(2, 16'h1000 + 16'(k));
    end
    @(negedge clk);

    // Timeout: no mem_resp; error completion exactly 8 cycles after cs rises.
    push_rsp(0, 16'h0000, 1'b1);
    issue(0, 1'b0, 14'h0AAA, 16'h0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk_eq("to_cs_held", 32'(cs), 32'd1);
      chk_eq("to_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk_eq("to_rsp", 32'(rsp_valid), 32'd1);
    chk_eq("to_err", 32'(rsp_err), 32'd1);
    chk_eq("to_cs_drop", 32'(cs), 32'd0);
    // Late mem_resp is ignored.
    mem_resp = 1'b1; datafrommem = 16'h1234;
    @(negedge clk);
    mem_resp = 1'b0; datafrommem = '0;
    chk_eq("late_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk_eq("late_no_rsp2", 32'(rsp_valid), 32'd0);
    chk_eq("late_busy", 32'(busy), 32'd0);

    // Reset two cycles into WAIT_RESP drops the transaction.
    issue(1, 1'b0, 14'h0222, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("mrst_cs", 32'(cs), 32'd0);
    chk_eq("mrst_rd", 32'(read_req), 32'd0);
    chk_eq("mrst_busy", 32'(busy), 32'd0);
    chk_eq("mrst_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    // After reset requester 0 has priority.
    req_addr  = {14'h0333, 14'h0777};
    req_write = '0;
    req_valid = 2'b11;
    ack_q.push_back(0);
    push_rsp(0, 16'h7777, 1'b0);
    exp_addr = 14'h0777; exp_wr = 1'b0;
    wait_ack(n);
    req_valid = '0;
    chk_eq("post_rst_lat", 32'(n), 32'd1);
    check_port_held("post_rst");
    mem_reply(3, 16'h7777);
    @(negedge clk);

    // Request pulsed and withdrawn while busy: never acked.
    push_rsp(0, 16'h4444, 1'b0);
    issue(0, 1'b0, 14'h0444, 16'h0);
    req_addr[14 +: 14] = 14'h0555; req_write[1] = 1'b0; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    mem_reply(3, 16'h4444);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("wd_no_ack", 32'(req_ack), 32'd0);
    end

    // Stray mem_resp while idle.
    mem_resp = 1'b1; datafrommem = 16'hFFFF;
    @(negedge clk);
    mem_resp = 1'b0; datafrommem = '0;
    chk_eq("stray_rsp", 32'(rsp_valid), 32'd0);
    chk_eq("stray_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk_eq("stray_rsp2", 32'(rsp_valid), 32'd0);
    chk_eq("stray_cs", 32'(cs), 32'd0);

    chk_eq("ack_q_empty", 32'(ack_q.size()), 32'd0);
    chk_eq("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
